// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller: sequences a sync-read line RAM between a CPU word port and a line-wide memory port.
// Hit completes in the cycle after accept; misses complete in the refill ack cycle; memory requests hold until mem_ack.
module cache_ctrl #(
  parameter int Index_width = 7,
  parameter int Block_width = 128,
  parameter int Tag_width   = 21
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [31:0]            cpu_addr,
  input  logic [31:0]            cpu_wdata,
  output logic [31:0]            cpu_rdata,
  output logic                   cpu_ready,
  output logic                   data_en,
  output logic [Index_width-1:0] data_addr,
  output logic [Block_width-1:0] data_din,
  input  logic [Block_width-1:0] data_dout,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [Block_width-1:0] mem_wdata,
  input  logic [Block_width-1:0] mem_rdata,
  input  logic                   mem_ack,
  output logic [15:0]            hit_cnt,
  output logic [15:0]            miss_cnt
);

  localparam int Sets = 1 << Index_width;

  typedef enum logic [1:0] {IDLE, LOOKUP, WB, REFILL} state_t;

  state_t                 state;
  logic [Tag_width-1:0]   tag_ram [Sets];
  logic [Sets-1:0]        valid;
  logic [Sets-1:0]        dirty;
  logic [31:2]            req_addr;
  logic                   req_we;
  logic [31:0]            req_wdata;
  logic [Block_width-1:0] line_buf;
  logic [15:0]            hit_q;
  logic [15:0]            miss_q;

  logic [Index_width-1:0] idx;
  logic [Tag_width-1:0]   req_tag;
  logic [1:0]             word;
  logic                   hit;
  logic [Block_width-1:0] fill_line;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

  assign idx     = req_addr[4 +: Index_width];
  assign req_tag = req_addr[31 -: Tag_width];
  assign word    = req_addr[3:2];
  assign hit     = valid[idx] && (tag_ram[idx] == req_tag);

  function automatic logic [Block_width-1:0] merge_word(
    input logic [Block_width-1:0] line,
    input logic [1:0]             w,
    input logic [31:0]            d
  );
    logic [Block_width-1:0] m;
    m = line;
    m[{w, 5'b0} +: 32] = d;
    return m;
  endfunction

  assign fill_line = req_we ? merge_word(mem_rdata, word, req_wdata) : mem_rdata;
  assign hit_cnt   = hit_q;
  assign miss_cnt  = miss_q;

  // Outputs are decoded from state so a hit or refill ack completes in the same cycle.
  always_comb begin
    cpu_rdata = '0;
    cpu_ready = 1'b0;
    data_en   = 1'b0;
    data_din  = '0;
    data_addr = (state == IDLE) ? cpu_addr[4 +: Index_width] : idx;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      LOOKUP: begin
        if (hit) begin
          cpu_ready = 1'b1;
          if (req_we) begin
            data_en  = 1'b1;
            data_din = merge_word(data_dout, word, req_wdata);
          end else begin
            cpu_rdata = data_dout[{word, 5'b0} +: 32];
          end
        end
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_ram[idx], idx, 4'b0};
        mem_wdata = line_buf;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, idx, 4'b0};
        if (mem_ack) begin
          data_en   = 1'b1;
          data_din  = fill_line;
          cpu_ready = 1'b1;
          cpu_rdata = fill_line[{word, 5'b0} +: 32];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      valid     <= '0;
      dirty     <= '0;
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      line_buf  <= '0;
      hit_q     <= '0;
      miss_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_addr  <= cpu_addr[31:2];
            req_we    <= cpu_we;
            req_wdata <= cpu_wdata;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            hit_q <= hit_q + 16'd1;
            if (req_we) dirty[idx] <= 1'b1;
            state <= IDLE;
          end else begin
            miss_q <= miss_q + 16'd1;
            if (valid[idx] && dirty[idx]) begin
              line_buf <= data_dout;
              state    <= WB;
            end else begin
              state <= REFILL;
            end
          end
        end
        WB: begin
          if (mem_ack) state <= REFILL;
        end
        REFILL: begin
          if (mem_ack) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= req_we;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tags are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ack) tag_ram[idx] <= req_tag;
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: sync-read line RAM model, latency-programmable memory responder,
// and a scoreboard of expected load data popped on every cpu_ready.
module tb_cache_ctrl;

  logic         clk = 1'b0;
  logic         rstn;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_ready;
  logic         data_en;
  logic [6:0]   data_addr;
  logic [127:0] data_din, data_dout;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ack;
  logic [15:0]  hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  cache_ctrl #(.Index_width(7), .Block_width(128), .Tag_width(21)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .data_en(data_en), .data_addr(data_addr), .data_din(data_din), .data_dout(data_dout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  logic [127:0] ram [128];
  always @(posedge clk) begin
    if (data_en) ram[data_addr] <= data_din;
    data_dout <= ram[data_addr];
  end

  typedef struct packed {logic we; logic [31:0] addr; logic [127:0] wdata;} mtx_t;
  typedef struct packed {logic ld; logic [31:0] d;} sb_t;

  logic [127:0] backing [bit [31:0]];
  mtx_t         mlog[$];
  sb_t          sb_q[$];
  mtx_t         cur;
  bit           req_active;
  int           wait_cnt, ack_delay, unstable, n_ready;
  bit           saw_en;
  logic [127:0] last_din;
  int           n_checks = 0, n_fail = 0;
  int           lat;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: observe at negedge, then drive memory/cpu inputs just after the rising edge.
  task automatic step();
    bit ready_now, ack_now;
    sb_t e;
    @(negedge clk);
    ready_now = cpu_ready;
    ack_now   = mem_ack;
    if (cpu_ready) begin
      n_ready++;
      if (sb_q.size() == 0) check_eq("unexpected_ready", 1, 0);
      else begin
        e = sb_q.pop_front();
        if (e.ld) check_eq("load_rdata", cpu_rdata, e.d);
      end
    end
    if (data_en) begin saw_en = 1; last_din = data_din; end
    if (mem_req && !mem_ack) begin
      if (!req_active) begin
        req_active = 1; wait_cnt = 0;
        cur.we = mem_we; cur.addr = mem_addr; cur.wdata = mem_wdata;
      end else if (mem_we !== cur.we || mem_addr !== cur.addr || (cur.we && mem_wdata !== cur.wdata))
        unstable++;
    end
    @(posedge clk);
    #1;
    if (ack_now) begin
      mem_ack = 0; mem_rdata = '0;
    end else if (req_active && mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack = 1;
        mlog.push_back(cur);
        if (cur.we) backing[cur.addr] = cur.wdata;
        else mem_rdata = backing.exists(cur.addr) ? backing[cur.addr] : '0;
        req_active = 0;
      end else wait_cnt++;
    end
    if (ready_now) cpu_req = 0;
  endtask

  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp, output int l);
    int got;
    sb_q.push_back('{ld: !we, d: exp});
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    got = n_ready; l = 0;
    while (n_ready == got && l < 300) begin step(); l++; end
    if (n_ready == got) begin
      check_eq("access_timeout", 0, 1);
      cpu_req = 0; sb_q.delete();
    end
  endtask

  initial begin
    rstn = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    mem_ack = 0; mem_rdata = '0;
    req_active = 0; ack_delay = 0; unstable = 0; n_ready = 0; saw_en = 0; last_din = '0;
    for (int i = 0; i < 128; i++) ram[i] = '0;
    backing[32'h10]   = 128'h00000000_44443333_22221111_00009999;
    backing[32'h810]  = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    backing[32'h2000] = 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A;
    backing[32'h1810] = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cpu_ready", cpu_ready, 0);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_data_en", data_en, 0);
    check_eq("rst_outputs", {cpu_rdata, mem_addr, mem_we}, 0);
    check_eq("rst_lines", {mem_wdata, data_din}, 0);
    check_eq("rst_counters", {hit_cnt, miss_cnt}, 0);
    @(negedge clk) rstn = 1;
    @(posedge clk);
    #1;

    // Cold load then hit on the same line
    mlog.delete();
    access(0, 32'h14, 0, 32'h22221111, lat);
    check_eq("cold_mlog_n", mlog.size(), 1);
    if (mlog.size() >= 1) check_eq("cold_fetch", {mlog[0].we, mlog[0].addr}, {1'b0, 32'h10});
    check_eq("cold_miss_cnt", miss_cnt, 1);
    mlog.delete();
    access(0, 32'h14, 0, 32'h22221111, lat);
    check_eq("hit_latency", lat, 2);
    check_eq("hit_no_mem", mlog.size(), 0);
    check_eq("hit_cnt", hit_cnt, 1);

    // Store hit, then load back
    saw_en = 0;
    access(1, 32'h18, 32'hDEADBEEF, 0, lat);
    check_eq("store_en", saw_en, 1);
    check_eq("store_din", last_din, 128'h00000000_DEADBEEF_22221111_00009999);
    access(0, 32'h18, 0, 32'hDEADBEEF, lat);

    // Conflict miss on a dirty line
    mlog.delete();
    access(0, 32'h810, 0, 32'hA0A0A0A0, lat);
    check_eq("conf_mlog_n", mlog.size(), 2);
    if (mlog.size() >= 2) begin
      check_eq("conf_wb", {mlog[0].we, mlog[0].addr}, {1'b1, 32'h10});
      check_eq("conf_wb_data", mlog[0].wdata, 128'h00000000_DEADBEEF_22221111_00009999);
      check_eq("conf_fetch", {mlog[1].we, mlog[1].addr}, {1'b0, 32'h810});
    end
    mlog.delete();
    access(0, 32'h10, 0, 32'h00009999, lat);
    check_eq("clean_after_refill", mlog.size(), 1);
    if (mlog.size() >= 1) check_eq("clean_fetch", {mlog[0].we, mlog[0].addr}, {1'b0, 32'h10});

    // Store miss allocates, then eviction writes it back
    mlog.delete(); saw_en = 0;
    access(1, 32'h2004, 32'h12345678, 0, lat);
    check_eq("alloc_fetch_n", mlog.size(), 1);
    if (mlog.size() >= 1) check_eq("alloc_fetch", {mlog[0].we, mlog[0].addr}, {1'b0, 32'h2000});
    check_eq("alloc_din", last_din, 128'h0D0D0D0D_0C0C0C0C_12345678_0A0A0A0A);
    mlog.delete();
    access(0, 32'h4004, 0, 32'h0, lat);
    check_eq("alloc_evict_n", mlog.size(), 2);
    if (mlog.size() >= 2) begin
      check_eq("alloc_wb", {mlog[0].we, mlog[0].addr}, {1'b1, 32'h2000});
      check_eq("alloc_wb_data", mlog[0].wdata, 128'h0D0D0D0D_0C0C0C0C_12345678_0A0A0A0A);
      check_eq("alloc_fetch2", {mlog[1].we, mlog[1].addr}, {1'b0, 32'h4000});
    end

    // Slow memory on a dirty miss
    access(1, 32'h1C, 32'h55AA55AA, 0, lat);
    mlog.delete(); ack_delay = 7; unstable = 0;
    access(0, 32'h1810, 0, 32'hC0C0C0C0, lat);
    check_eq("slow_latency", lat, 20);
    check_eq("slow_stable", unstable, 0);
    if (mlog.size() >= 1)
      check_eq("slow_wb_data", mlog[0].wdata, 128'h55AA55AA_DEADBEEF_22221111_00009999);
    else check_eq("slow_mlog_n", mlog.size(), 2);
    ack_delay = 0;

    // Reset while a writeback is outstanding
    access(1, 32'h1810, 32'h0BADF00D, 0, lat);
    ack_delay = 30; mlog.delete();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_wdata = 0;
    for (int i = 0; i < 10 && !(req_active && cur.we); i++) step();
    check_eq("midrst_in_wb", {req_active, cur.we}, 2'b11);
    #2 rstn = 0;
    #1;
    check_eq("midrst_mem_req", mem_req, 0);
    check_eq("midrst_cpu_ready", cpu_ready, 0);
    cpu_req = 0; mem_ack = 0; req_active = 0;
    repeat (2) step();
    rstn = 1;
    step();
    check_eq("midrst_counters", {hit_cnt, miss_cnt}, 0);
    ack_delay = 0; mlog.delete();
    access(0, 32'h10, 0, 32'h00009999, lat);
    check_eq("postrst_latency", lat, 4);
    check_eq("postrst_mlog_n", mlog.size(), 1);
    if (mlog.size() >= 1) check_eq("postrst_fetch", {mlog[0].we, mlog[0].addr}, {1'b0, 32'h10});
    check_eq("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Direct-mapped, write-back, write-allocate cache controller that sequences the 128-set × 128-bit cache data RAM between a 32-bit CPU load/store port and a 128-bit line-wide memory port. It holds tag/valid/dirty state internally, drives the data RAM's single enable/address/data port, and runs lookup, writeback and refill. It sits between the CPU datapath and the memory model. The data RAM read is synchronous: its address is latched every cycle and its write is gated by `en`.

## Interface
Parameters:
- `Index_width`, 7, set index width (128 sets)
- `Block_width`, 128, line width in bits (4 × 32-bit words)
- `Tag_width`, 21, address bits [31:11]

Ports:
- `clk` in 1: clock, rising edge
- `rstn` in 1: asynchronous, active-low reset
- `cpu_req` in 1: access request, held high until `cpu_ready`
- `cpu_we` in 1: 1 = store, 0 = load
- `cpu_addr` in 32: byte address; word = [3:2], index = [10:4], tag = [31:11]
- `cpu_wdata` in 32: store data
- `cpu_rdata` out 32: load data, valid while `cpu_ready` = 1
- `cpu_ready` out 1: one-cycle completion pulse
- `data_en` out 1: data RAM write enable
- `data_addr` out `Index_width`: data RAM address
- `data_din` out `Block_width`: data RAM write line
- `data_dout` in `Block_width`: data RAM read line (from the address latched on the previous edge)
- `mem_req` out 1: memory request
- `mem_we` out 1: 1 = line writeback, 0 = line fetch
- `mem_addr` out 32: line address, [3:0] = 0
- `mem_wdata` out `Block_width`: writeback line
- `mem_rdata` in `Block_width`: fetched line, valid with `mem_ack`
- `mem_ack` in 1: one-cycle completion from memory
- `hit_cnt`, `miss_cnt` out 16 each: wrapping access counters

## Operation
- **Internal state:**
  - `tag[128]`, not reset.
  - `valid[128]` and `dirty[128]`, cleared by reset.
  - Request latch (`addr`, `we`, `wdata`) and line buffer.
- **FSM states:** IDLE, LOOKUP, WB, REFILL.
- **IDLE:**
  - `data_addr = cpu_addr[10:4]` combinationally.
  - On `cpu_req`, latch the request and go to LOOKUP.
- **LOOKUP:**
  - `data_addr` = latched index.
  - Hit = `valid[idx]` and `tag[idx] == latched tag`.
  - On a hit, `hit_cnt` += 1 and `cpu_ready` = 1, then go to IDLE:
    - Load: `cpu_rdata = data_dout[32*word +: 32]`.
    - Store: `data_en = 1`, `data_din` = `data_dout` with the selected word replaced by `wdata`, `dirty[idx] = 1`.
  - On a miss, `miss_cnt` += 1, then:
    - If `valid` and `dirty`, capture `data_dout` into the line buffer and go to WB.
    - Otherwise go to REFILL.
- **WB:**
  - `mem_req = 1`, `mem_we = 1`, `mem_addr = {tag[idx], idx, 4'b0}`, `mem_wdata` = line buffer.
  - On `mem_ack`, go to REFILL.
- **REFILL:**
  - `mem_req = 1`, `mem_we = 0`, `mem_addr = {latched tag, idx, 4'b0}`.
  - On `mem_ack`:
    - `data_en = 1`; `data_din = mem_rdata`, with the word merged with `wdata` if the request is a store.
    - `tag[idx]` = latched tag, `valid = 1`, `dirty = we`.
    - `cpu_ready = 1`; `cpu_rdata` = the selected word of the merged line.
    - Go to IDLE.
- `data_en` is 0 in every case not listed above.

## Timing
- **Reset values:** state IDLE; `cpu_ready`, `mem_req`, `mem_we`, `data_en` = 0; `cpu_rdata`, `mem_addr`, `mem_wdata`, `data_din` = 0; counters = 0; all valid/dirty = 0.
- **Reset mid-operation:** reset asserted in any state drops `mem_req` immediately (asynchronous) and abandons the access with no `cpu_ready`.
- **Hit latency:** request sampled at edge N, `cpu_ready` high during cycle N+1.
- **Clean-miss latency:** ack-cycle + 1; `cpu_ready` is asserted in the same cycle as the refill `mem_ack`.
- **Dirty miss:** WB completes before REFILL starts. `mem_req` stays high across the WB→REFILL edge, but `mem_we`/`mem_addr` change. No refill is issued before the writeback ack.
- **Memory handshake:** `mem_req` and its `mem_addr`/`mem_we`/`mem_wdata` stay stable until `mem_ack` is sampled. `mem_ack` while `mem_req` = 0 is ignored.
- **Back-to-back accesses:** after `cpu_ready`, a new `cpu_req` is accepted in the following IDLE cycle.
- **Same-line store then load:** the store's RAM write (edge N+2) precedes the next lookup's read latch, so the load returns the stored data.
- **Counter width:** both counters wrap 0xFFFF → 0x0000.

## Test plan
1. **Cold load:** after reset, load 0x0000_0014.
   - Expect: miss, `mem_req` with `mem_addr` = 0x10, `mem_we` = 0.
   - Return `mem_rdata` = 0x44443333_22221111_00009999.
   - Expect: `cpu_rdata` = 0x22221111 in the ack cycle, `miss_cnt` = 1.
   - Repeat the load: expect `cpu_ready` one cycle after accept, no `mem_req`, `hit_cnt` = 1.
2. **Store hit:** store 0xDEADBEEF to 0x18 (word 2).
   - Expect: `data_en` = 1, `data_din[95:64]` = 0xDEADBEEF, other words unchanged.
   - Load 0x18: expect 0xDEADBEEF.
3. **Conflict miss:** load 0x0000_0810 (same index 1, new tag).
   - Expect: first `mem_we` = 1, `mem_addr` = 0x10, `mem_wdata[95:64]` = 0xDEADBEEF.
   - After ack, expect `mem_we` = 0, `mem_addr` = 0x810.
   - Expect `dirty[1]` = 0 afterwards.
4. **Store miss (write-allocate):** store 0x12345678 to 0x2004.
   - Expect: a refill from 0x2000, and the line written with word 1 = 0x12345678.
   - Then load 0x4004 (same index): expect a writeback to 0x2000 carrying that word.
5. **Delayed ack:** hold `mem_ack` low for 7 cycles.
   - Expect `mem_req`, `mem_addr`, `mem_wdata` constant and no `cpu_ready` until ack.
6. **Reset mid-writeback:** pulse `rstn` low during WB.
   - Expect `mem_req` = 0 asynchronously and no `cpu_ready`.
   - Load 0x10 afterwards: expect a clean miss (fetch only, no writeback).
